// File: rtl/cache_bus_arbiter_pkg.sv
// Shared cache-bus package: the bus sequencer states, the size limit and a
// one-hot to index helper.
//   max_caches_c  largest supported number of caches
//   ptr_w_c       width of a cache index / round-robin pointer
//   bus_state_t   transaction sequencer states
package cache_bus_arbiter_pkg;

    localparam int unsigned max_caches_c = 16;
    localparam int unsigned ptr_w_c      = $clog2(max_caches_c);

    typedef enum logic [2:0] {
        s_idle,
        s_grant,
        s_snoop,
        s_mem,
        s_done
    } bus_state_t;

    // Index of the (single) set bit of a one-hot vector; 0 when empty.
    function automatic logic [ptr_w_c-1:0] onehot_to_idx(input logic [max_caches_c-1:0] v);
        logic [ptr_w_c-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < max_caches_c; i++) begin
            if (v[i]) idx = ptr_w_c'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Coherence bus bundle between the cache controllers / memory port and the
// bus arbiter.
//   req_i, snoop_ack_i, snoop_hit_i, snoop_supply_i, mem_done_i : into arbiter
//   grant_o, snoop_v_o, mem_v_o, done_o, shared_o               : from arbiter
// modport master: cache/memory side; modport slave: arbiter side.
interface cache_bus_arbiter_if #(
    parameter int unsigned num_caches_p = 4
) ();

    logic [num_caches_p-1:0] req_i;
    logic [num_caches_p-1:0] grant_o;
    logic                    snoop_v_o;
    logic [num_caches_p-1:0] snoop_ack_i;
    logic [num_caches_p-1:0] snoop_hit_i;
    logic [num_caches_p-1:0] snoop_supply_i;
    logic                    mem_v_o;
    logic                    mem_done_i;
    logic [num_caches_p-1:0] done_o;
    logic                    shared_o;

    modport master (
        output req_i, snoop_ack_i, snoop_hit_i, snoop_supply_i, mem_done_i,
        input  grant_o, snoop_v_o, mem_v_o, done_o, shared_o
    );

    modport slave (
        input  req_i, snoop_ack_i, snoop_hit_i, snoop_supply_i, mem_done_i,
        output grant_o, snoop_v_o, mem_v_o, done_o, shared_o
    );

endinterface

// File: rtl/cache_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     per-cache request vector
//   start   index that currently has highest priority (kept by the parent)
//   pick_c  one-hot winner, all-zero when no request
module rr_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int unsigned num_caches_p = 4
) (
    input  logic [num_caches_p-1:0] req,
    input  logic [ptr_w_c-1:0]      start,
    output logic [num_caches_p-1:0] pick_c
);

    int unsigned idx;
    logic        found;

    // Scan from start upwards with wrap; first requester wins.
    always_comb begin
        pick_c = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < num_caches_p; i++) begin
            idx = 32'(start) + i;
            if (idx >= num_caches_p) idx = idx - num_caches_p;
            if (!found && req[idx]) begin
                pick_c[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Coherence bus arbiter: grants the shared snooping bus round-robin, broadcasts
// the snoop, collects per-peer acks, fetches from memory when no peer supplies
// the block and pulses completion with the shared indication.
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   bus      arbiter side (slave) of cache_bus_arbiter_if
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int unsigned num_caches_p = 4
) (
    input logic                clk_i,
    input logic                reset_i,
    cache_bus_arbiter_if.slave bus
);

    bus_state_t              state;
    logic [num_caches_p-1:0] grant;
    logic                    snoop_v;
    logic                    mem_v;
    logic [num_caches_p-1:0] done;
    logic                    shared;
    logic [num_caches_p-1:0] mask;
    logic                    hit;
    logic                    supply;
    logic [ptr_w_c-1:0]      start;

    logic [num_caches_p-1:0] pick_c;
    logic [num_caches_p-1:0] peer_ack_c;
    logic [num_caches_p-1:0] mask_next_c;
    logic                    hit_next_c;
    logic                    supply_next_c;
    logic [ptr_w_c-1:0]      win_idx_c;

    rr_arbiter #(.num_caches_p(num_caches_p)) u_rr (
        .req    (bus.req_i),
        .start  (start),
        .pick_c (pick_c)
    );

    // Requester's own ack never contributes hit/supply information.
    assign peer_ack_c    = bus.snoop_ack_i & ~grant;
    assign mask_next_c   = mask | bus.snoop_ack_i;
    assign hit_next_c    = hit | (|(peer_ack_c & bus.snoop_hit_i));
    assign supply_next_c = supply | (|(peer_ack_c & bus.snoop_supply_i));
    assign win_idx_c     = onehot_to_idx(max_caches_c'(grant));

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= s_idle;
            grant   <= '0;
            snoop_v <= 1'b0;
            mem_v   <= 1'b0;
            done    <= '0;
            shared  <= 1'b0;
            mask    <= '0;
            hit     <= 1'b0;
            supply  <= 1'b0;
            start   <= '0;
        end else begin
            case (state)
                s_idle: begin
                    if (|bus.req_i) begin
                        grant   <= pick_c;
                        snoop_v <= 1'b1;
                        mask    <= pick_c;
                        hit     <= 1'b0;
                        supply  <= 1'b0;
                        state   <= s_grant;
                    end
                end
                s_grant, s_snoop: begin
                    snoop_v <= 1'b0;
                    mask    <= mask_next_c;
                    hit     <= hit_next_c;
                    supply  <= supply_next_c;
                    if (&mask_next_c) begin
                        if (supply_next_c) begin
                            done   <= grant;
                            shared <= hit_next_c;
                            state  <= s_done;
                        end else begin
                            mem_v <= 1'b1;
                            state <= s_mem;
                        end
                    end else begin
                        state <= s_snoop;
                    end
                end
                s_mem: begin
                    if (bus.mem_done_i) begin
                        mem_v  <= 1'b0;
                        done   <= grant;
                        shared <= hit;
                        state  <= s_done;
                    end
                end
                s_done: begin
                    done   <= '0;
                    shared <= 1'b0;
                    grant  <= '0;
                    // Next priority goes to the cache after the winner.
                    if (32'(win_idx_c) + 1 >= num_caches_p) start <= '0;
                    else                                    start <= win_idx_c + 1'b1;
                    state  <= s_idle;
                end
                default: state <= s_idle;
            endcase
        end
    end

    assign bus.grant_o   = grant;
    assign bus.snoop_v_o = snoop_v;
    assign bus.mem_v_o   = mem_v;
    assign bus.done_o    = done;
    assign bus.shared_o  = shared;

endmodule
